// File: rtl/exc_int_sequencer.sv
// Exception/interrupt entry sequencer: accepts an event, flushes the pipe, pushes PC
// and flags to the stack path, then vectors to the cause-indexed handler.
module exc_int_sequencer #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  exc_req,
    input  logic [31:0] exc_pc,
    input  logic [2:0]  int_req,
    input  logic [31:0] cur_pc,
    input  logic [3:0]  cur_flags,
    input  logic        rti,
    input  logic        push_ready,
    output logic        flush,
    output logic        stall,
    output logic        push_valid,
    output logic [31:0] push_data,
    output logic        pc_load,
    output logic [31:0] pc_vector,
    output logic        in_service,
    output logic [2:0]  cause
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        PUSH_PC,
        PUSH_FLG,
        VECTOR,
        SERVICE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  int_pend;
    logic [2:0]  pend_clr;
    logic [31:0] saved_pc;
    logic [3:0]  saved_flg;
    logic [2:0]  cause_q;

    logic        exc_hit;
    logic [1:0]  exc_idx;
    logic [1:0]  int_idx;
    logic        accept_exc;
    logic        accept_int;
    logic [2:0]  accept_cause;

    // Event selection: exceptions beat interrupts, lowest index wins within each group.
    always_comb begin
        exc_hit = |exc_req;
        exc_idx = 2'd0;
        if (exc_req[0])      exc_idx = 2'd0;
        else if (exc_req[1]) exc_idx = 2'd1;
        else if (exc_req[2]) exc_idx = 2'd2;
        else if (exc_req[3]) exc_idx = 2'd3;

        int_idx = 2'd0;
        if (int_pend[0])      int_idx = 2'd0;
        else if (int_pend[1]) int_idx = 2'd1;
        else if (int_pend[2]) int_idx = 2'd2;

        accept_exc   = exc_hit && ((state == IDLE) || (state == SERVICE));
        accept_int   = (state == IDLE) && !exc_hit && (|int_pend);
        accept_cause = accept_exc ? {1'b0, exc_idx} : {1'b1, int_idx};
        pend_clr     = accept_int ? (3'b001 << int_idx) : 3'b000;
    end

    // Next-state logic; an exception in SERVICE takes precedence over a same-cycle rti.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept_exc || accept_int) state_next = FLUSH;
            FLUSH:    state_next = PUSH_PC;
            PUSH_PC:  if (push_ready) state_next = PUSH_FLG;
            PUSH_FLG: if (push_ready) state_next = VECTOR;
            VECTOR:   state_next = SERVICE;
            SERVICE: begin
                if (accept_exc)  state_next = FLUSH;
                else if (rti)    state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // Reset overrides everything, including pulses arriving on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            int_pend  <= 3'b000;
            saved_pc  <= 32'h0;
            saved_flg <= 4'h0;
            cause_q   <= 3'd0;
        end else begin
            state    <= state_next;
            int_pend <= (int_pend & ~pend_clr) | int_req;
            if (accept_exc || accept_int) begin
                saved_pc  <= accept_exc ? exc_pc : cur_pc;
                saved_flg <= cur_flags;
                cause_q   <= accept_cause;
            end
        end
    end

    // Outputs decode only the registered state and registered context.
    always_comb begin
        flush      = (state == FLUSH);
        stall      = (state == FLUSH) || (state == PUSH_PC) ||
                     (state == PUSH_FLG) || (state == VECTOR);
        push_valid = (state == PUSH_PC) || (state == PUSH_FLG);
        push_data  = 32'h0;
        if (state == PUSH_PC)       push_data = saved_pc;
        else if (state == PUSH_FLG) push_data = {28'b0, saved_flg};
        pc_load    = (state == VECTOR);
        pc_vector  = VEC_BASE + {27'b0, cause_q, 2'b00};
        in_service = (state == SERVICE);
        cause      = cause_q;
    end

endmodule

// File: doc/exc_int_sequencer.md
EXC_INT_SEQUENCER -- requirements
Module: exc_int_sequencer

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0100, base address of the cause-indexed vector table.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 exc_req  input  4  one-hot exception request, one-cycle pulses.
REQ-005 exc_pc  input  32  PC of faulting instruction, sampled with exc_req.
REQ-006 int_req  input  3  interrupt request pulses, one bit per source.
REQ-007 cur_pc  input  32  next sequential PC, sampled for interrupts.
REQ-008 cur_flags  input  4  CCR flags (Z,N,C,V), sampled at acceptance.
REQ-009 rti  input  1  one-cycle pulse, return-from-interrupt executed.
REQ-010 push_ready  input  1  memory stage accepts push this cycle.
REQ-011 flush  output  1  kill all in-flight pipeline instructions.
REQ-012 stall  output  1  freeze fetch/decode.
REQ-013 push_valid  output  1  push request to stack path.
REQ-014 push_data  output  32  word to push.
REQ-015 pc_load  output  1  load pc_vector into PC this cycle.
REQ-016 pc_vector  output  32  handler address.
REQ-017 in_service  output  1  handler running, interrupts masked.
REQ-018 cause  output  3  code of event in service.

Function
REQ-019 States SHALL be IDLE, FLUSH, PUSH_PC, PUSH_FLG, VECTOR, SERVICE.
REQ-020 Pending register int_pend[2:0] SHALL set on int_req bit, clear on acceptance of that bit; set wins over same-cycle clear.
REQ-021 Accept priority: exc_req over int_pend; within each, lowest index first; cause = index for exceptions (0-3), 4+index for interrupts (4-6).
REQ-022 Exceptions SHALL be accepted in IDLE or SERVICE; interrupts only in IDLE.
REQ-023 Exception pulse arriving in FLUSH/PUSH_PC/PUSH_FLG/VECTOR SHALL be dropped; interrupt pulses in any state SHALL be latched.
REQ-024 On acceptance, saved_pc <= exc_pc (exception) or cur_pc (interrupt); saved_flg <= cur_flags; cause registered; next state FLUSH.
REQ-025 FLUSH: flush=1, stall=1 for exactly one cycle; -> PUSH_PC.
REQ-026 PUSH_PC: push_valid=1, push_data=saved_pc, held stable until push_ready; on push_ready -> PUSH_FLG.
REQ-027 PUSH_FLG: push_valid=1, push_data={28'b0,saved_flg}, held until push_ready; -> VECTOR.
REQ-028 VECTOR: pc_load=1 one cycle, pc_vector = VEC_BASE + {27'b0,cause,2'b00} (mod 2^32); -> SERVICE.
REQ-029 stall=1 in FLUSH, PUSH_PC, PUSH_FLG, VECTOR; 0 in IDLE, SERVICE.
REQ-030 SERVICE: in_service=1; rti -> IDLE; exception in SERVICE re-enters FLUSH (nesting permitted for exceptions only).
REQ-031 rti and exception same cycle in SERVICE: exception wins, rti ignored.
REQ-032 rti outside SERVICE SHALL be ignored.
REQ-033 Acceptance-to-pc_load latency with push_ready tied high SHALL be 4 cycles (FLUSH, PUSH_PC, PUSH_FLG, VECTOR).
REQ-034 push_valid/pc_load/flush SHALL be registered-state decodes, glitch-free, never asserted in IDLE or SERVICE.

Reset
REQ-035 reset SHALL force IDLE, int_pend=0, saved_pc=0, saved_flg=0, cause=0 on the next edge, overriding any state incl. mid-push.
REQ-036 During/after reset all outputs SHALL be 0 (pc_vector=VEC_BASE) until a new acceptance.
REQ-037 int_req/exc_req coincident with reset SHALL be discarded.

Verification
REQ-038 int_req=3'b010, cur_pc=32'h40, flags=4'b0101, push_ready=1 -> flush, pushes 32'h40 then 32'h5, pc_load with pc_vector=32'h114, in_service=1, cause=5.
REQ-039 exc_req=4'b0100 and int_req=3'b001 same cycle, exc_pc=32'h88 -> cause=2, pc_vector=32'h108; after rti, interrupt 0 serviced, pc_vector=32'h110.
REQ-040 push_ready low 3 cycles in PUSH_PC -> push_valid and push_data=saved_pc stable all 3 cycles, stall=1 throughout, no state advance.
REQ-041 int_req=3'b100 during SERVICE -> not taken until rti; then pc_vector=32'h118 after 4 cycles.
REQ-042 reset asserted in PUSH_FLG -> next cycle IDLE, all outputs 0, pending cleared; no pc_load follows.
